// File: rtl/ps2_space_detect_if.sv
// ps2_space_detect_if
//   Bundles the PS/2 line inputs and the decoded key-event outputs of
//   ps2_space_detect.
//   master : drives the PS/2 lines, observes key events (keyboard side / bench)
//   slave  : receives the PS/2 lines, produces key events (the decoder)
//   ps2_clk, ps2_data       raw keyboard lines, asynchronous to the system clock
//   scan_code[7:0]          last accepted data byte
//   code_valid              one-cycle pulse, scan_code updated
//   is_break, is_ext        qualifiers of code_valid (F0 / E0 prefix seen)
//   space_pressed           one-cycle pulse on a fresh spacebar make
//   space_held              level, spacebar currently down
//   frame_err               one-cycle pulse on bad start/parity/stop or timeout
interface ps2_space_detect_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       is_break;
  logic       is_ext;
  logic       space_pressed;
  logic       space_held;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, code_valid, is_break, is_ext, space_pressed, space_held, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, code_valid, is_break, is_ext, space_pressed, space_held, frame_err
  );
endinterface

// File: rtl/ps2_space_detect.sv
// ps2_space_detect
//   PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines,
//   deserialises 11-bit frames, tracks E0/F0 prefixes and raises a single-cycle
//   start pulse on a fresh spacebar make.
//   i_clk    system clock (100 MHz)
//   i_rst_n  asynchronous active-low reset
//   bus      ps2_space_detect_if.slave: PS/2 lines in, key events out
module ps2_space_detect #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter logic [7:0]  SPACE_CODE     = 8'h29
) (
  input logic               i_clk,
  input logic               i_rst_n,
  ps2_space_detect_if.slave bus
);

  localparam int unsigned     FiltW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned     TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      ExtCode  = 8'hE0;
  localparam logic [7:0]      BrkCode  = 8'hF0;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input conditioning
  logic             r_clk_s1, r_clk_s2;
  logic             r_dat_s1, r_dat_s2;
  logic             r_clk_filt, r_clk_filt_q;
  logic [FiltW-1:0] r_filt_cnt;
  logic             w_fall;

  // Frame FSM
  state_e          r_state, w_state_next;
  logic [7:0]      r_shift, w_shift_next;
  logic [2:0]      r_bit_cnt, w_bit_cnt_next;
  logic            r_parity, w_parity_next;
  logic [TmoW-1:0] r_tmo_cnt;
  logic            w_timeout;
  logic            w_accept;
  logic            w_err;

  // Decode state and outputs
  logic       r_ext_pend, r_brk_pend;
  logic [7:0] r_scan_code;
  logic       r_code_valid;
  logic       r_is_break;
  logic       r_is_ext;
  logic       r_space_pressed;
  logic       r_space_held;
  logic       r_frame_err;

  // Synchronisers reset to the idle bus level so releasing reset cannot fake an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock follows only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_q <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_q <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FiltLast) begin
        r_filt_cnt <= '0;
        r_clk_filt <= r_clk_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_filt_q & ~r_clk_filt;

  // Mid-frame watchdog, restarted by every falling edge.
  assign w_timeout = (r_state != StIdle) && !w_fall && (r_tmo_cnt == TmoLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StIdle || w_fall || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_parity  <= w_parity_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_parity_next  = r_parity;
    w_accept       = 1'b0;
    w_err          = 1'b0;
    if (w_timeout) begin
      w_state_next = StIdle;
      w_err        = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        StIdle: begin
          if (!r_dat_s2) begin
            w_state_next   = StData;
            w_bit_cnt_next = 3'd0;
          end else begin
            w_err = 1'b1;
          end
        end
        StData: begin
          // LSB arrives first, so shift in from the top.
          w_shift_next   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = StParity;
          end
        end
        StParity: begin
          w_parity_next = r_dat_s2;
          w_state_next  = StStop;
        end
        StStop: begin
          w_state_next = StIdle;
          if (r_dat_s2 && (^{r_shift, r_parity})) begin
            w_accept = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Byte decode; all event outputs are registered one clock after the stop-bit fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext_pend      <= 1'b0;
      r_brk_pend      <= 1'b0;
      r_scan_code     <= 8'h00;
      r_code_valid    <= 1'b0;
      r_is_break      <= 1'b0;
      r_is_ext        <= 1'b0;
      r_space_pressed <= 1'b0;
      r_space_held    <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_code_valid    <= 1'b0;
      r_space_pressed <= 1'b0;
      r_frame_err     <= w_err;
      if (w_accept) begin
        if (r_shift == ExtCode) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == BrkCode) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_scan_code  <= r_shift;
          r_is_break   <= r_brk_pend;
          r_is_ext     <= r_ext_pend;
          r_code_valid <= 1'b1;
          r_ext_pend   <= 1'b0;
          r_brk_pend   <= 1'b0;
          // Extended 0x29 is a different key and never touches space tracking.
          if (r_shift == SPACE_CODE && !r_ext_pend) begin
            if (r_brk_pend) begin
              r_space_held <= 1'b0;
            end else if (!r_space_held) begin
              r_space_pressed <= 1'b1;
              r_space_held    <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.scan_code     = r_scan_code;
  assign bus.code_valid    = r_code_valid;
  assign bus.is_break      = r_is_break;
  assign bus.is_ext        = r_is_ext;
  assign bus.space_pressed = r_space_pressed;
  assign bus.space_held    = r_space_held;
  assign bus.frame_err     = r_frame_err;

endmodule

// File: tb/tb_ps2_space_detect.sv
// tb_ps2_space_detect
//   Self-checking bench for ps2_space_detect. PS/2 frames are driven bit by bit;
//   a key-event model (prefix flags, held state, expected event queue) predicts
//   what the decoder must report.
module tb_ps2_space_detect;

  localparam int unsigned FilterLen     = 8;
  localparam int unsigned TimeoutCycles = 2000;
  localparam int unsigned Half          = 20;
  // Raw edge -> 2 sync flops -> FilterLen samples -> registered event.
  localparam int unsigned Lat           = FilterLen + 3;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       sp;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;

  ps2_space_detect_if bus ();

  ps2_space_detect #(
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .SPACE_CODE    (8'h29)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation side
  ev_t         obs_q[$];
  int unsigned obs_cyc[$];
  int          n_ferr_obs = 0;
  int unsigned ferr_cyc   = 0;
  int          n_stray_sp = 0;
  int          n_wide     = 0;
  logic        prev_cv    = 1'b0;
  logic        prev_fe    = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.code_valid) begin
        obs_q.push_back({bus.scan_code, bus.is_break, bus.is_ext, bus.space_pressed});
        obs_cyc.push_back(cyc);
      end
      if (bus.space_pressed && !bus.code_valid) n_stray_sp++;
      if (bus.frame_err) begin
        n_ferr_obs++;
        ferr_cyc = cyc;
      end
      if ((bus.code_valid && prev_cv) || (bus.frame_err && prev_fe)) n_wide++;
    end
    prev_cv = bus.code_valid;
    prev_fe = bus.frame_err;
  end

  // Reference model: key-event semantics only
  ev_t         exp_q[$];
  int          n_ferr_exp = 0;
  logic        m_ext, m_brk, m_held;
  logic [7:0]  m_scan;
  int unsigned last_fall_cyc = 0;

  function automatic void model_reset();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_held = 1'b0;
    m_scan = 8'h00;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit good);
    ev_t e;
    if (!good) begin
      n_ferr_exp++;
      return;
    end
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      e.code = b;
      e.brk  = m_brk;
      e.ext  = m_ext;
      e.sp   = (b == 8'h29) && !m_ext && !m_brk && !m_held;
      if (b == 8'h29 && !m_ext) m_held = !m_brk;
      exp_q.push_back(e);
      m_scan = b;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endfunction

  function automatic void clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    n_ferr_obs = 0;
    n_ferr_exp = 0;
    n_stray_sp = 0;
    n_wide     = 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic d, input bit glitch);
    bus.ps2_data = d;
    wait_cyc(5);
    bus.ps2_clk   = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(Half);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(12);
      bus.ps2_clk = 1'b0;
      wait_cyc(FilterLen - 2);
      bus.ps2_clk = 1'b1;
    end
    wait_cyc(Half);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic p;
    p = ~(^b);
    if (bad_par) p = ~p;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(!bad_stop, glitch);
    bus.ps2_data = 1'b1;
    wait_cyc(10);
    model_byte(b, !bad_par && !bad_stop);
  endtask

  task automatic apply_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    rst_n = 1'b1;
    model_reset();
    wait_cyc(5);
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    model_reset();
    wait_cyc(5);
    outs = {bus.scan_code, bus.code_valid, bus.is_break, bus.is_ext, bus.space_pressed,
            bus.space_held, bus.frame_err};
    n_checks++;
    if (outs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0000", outs);
    end
    rst_n = 1'b1;
    clear_obs();
    wait_cyc(1000);
    outs = {bus.scan_code, bus.code_valid, bus.is_break, bus.is_ext, bus.space_pressed,
            bus.space_held, bus.frame_err};
    n_checks++;
    if (outs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_idle_outputs: got %h want 0000", outs);
    end
    n_checks++;
    if (n_ferr_obs != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_events: got ferr=%0d cv=%0d want 0 0", n_ferr_obs,
               obs_q.size());
    end
  endtask

  task automatic test_space_press();
    clear_obs();
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL press_count: got %0d want 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL press_event: got %h want %h", obs_q[0], exp_q[0]);
      end
      n_checks++;
      if (obs_cyc[0] - last_fall_cyc != Lat) begin
        n_fail++;
        $display("FAIL press_latency: got %0d want %0d", obs_cyc[0] - last_fall_cyc, Lat);
      end
    end
    n_checks++;
    if (bus.space_held !== m_held || n_stray_sp != 0) begin
      n_fail++;
      $display("FAIL press_held: got %b stray=%0d want %b 0", bus.space_held, n_stray_sp,
               m_held);
    end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [5];
    int         n_sp;
    apply_reset();
    clear_obs();
    seq = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
    foreach (seq[i]) send_frame(seq[i], 1'b0, 1'b0, 1'b0);
    n_sp = 0;
    foreach (obs_q[i]) if (obs_q[i].sp) n_sp++;
    n_checks++;
    if (n_sp != 1) begin
      n_fail++;
      $display("FAIL typematic_press_once: got %0d want 1", n_sp);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL typematic_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL typematic_event%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (bus.space_held !== m_held) begin
      n_fail++;
      $display("FAIL typematic_release: got %b want %b", bus.space_held, m_held);
    end
  endtask

  task automatic test_parity_err();
    logic [7:0] prev;
    clear_obs();
    prev = m_scan;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (n_ferr_obs != n_ferr_exp || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_err: got ferr=%0d cv=%0d want %0d 0", n_ferr_obs, obs_q.size(),
               n_ferr_exp);
    end
    n_checks++;
    if (bus.scan_code !== prev) begin
      n_fail++;
      $display("FAIL parity_keep_code: got %h want %h", bus.scan_code, prev);
    end
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || bus.scan_code !== m_scan) begin
      n_fail++;
      $display("FAIL parity_recover: got cv=%0d code=%h want 1 %h", obs_q.size(),
               bus.scan_code, m_scan);
    end
  endtask

  task automatic test_ext();
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    clear_obs();
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL ext_count: got %0d want 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL ext_event: got %h want %h", obs_q[0], exp_q[0]);
      end
    end
    n_checks++;
    if (bus.space_held !== m_held) begin
      n_fail++;
      $display("FAIL ext_held: got %b want %b", bus.space_held, m_held);
    end
  endtask

  task automatic test_timeout();
    int unsigned fall_ref;
    int unsigned dly;
    clear_obs();
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    fall_ref = last_fall_cyc;
    bus.ps2_data = 1'b1;
    n_ferr_exp++;
    wait_cyc(TimeoutCycles + 100);
    n_checks++;
    if (n_ferr_obs != n_ferr_exp || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_err: got ferr=%0d cv=%0d want %0d 0", n_ferr_obs, obs_q.size(),
               n_ferr_exp);
    end
    dly = ferr_cyc - fall_ref;
    n_checks++;
    if (dly < TimeoutCycles || dly > TimeoutCycles + Lat + 3) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d want %0d..%0d", dly, TimeoutCycles,
               TimeoutCycles + Lat + 3);
    end
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL timeout_recover: got n=%0d ev=%h want %h", obs_q.size(),
               obs_q.size() ? obs_q[0] : ev_t'(0), exp_q[0]);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      bus.ps2_clk = 1'b0;
      wait_cyc($urandom_range(1, FilterLen - 2));
      bus.ps2_clk = 1'b1;
      wait_cyc($urandom_range(FilterLen + 3, 30));
    end
    n_checks++;
    if (n_ferr_obs != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_idle: got ferr=%0d cv=%0d want 0 0", n_ferr_obs, obs_q.size());
    end
    b = 8'($urandom_range(0, 255));
    if (b == 8'hE0 || b == 8'hF0) b = 8'h5A;
    send_frame(b, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || n_ferr_obs != 0 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL glitch_frame: got n=%0d ferr=%0d code=%h want 1 0 %h", obs_q.size(),
               n_ferr_obs, bus.scan_code, b);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [13:0] outs;
    logic [7:0]  b;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    outs = {bus.scan_code, bus.code_valid, bus.is_break, bus.is_ext, bus.space_pressed,
            bus.space_held, bus.frame_err};
    n_checks++;
    if (outs !== 14'h0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got %h want 0000", outs);
    end
    bus.ps2_data = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    model_reset();
    clear_obs();
    b = 8'($urandom_range(0, 255));
    if (b == 8'hE0 || b == 8'hF0) b = 8'h29;
    send_frame(b, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || n_ferr_obs != 0 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL midframe_recover: got n=%0d ferr=%0d code=%h want 1 0 %h",
               obs_q.size(), n_ferr_obs, bus.scan_code, b);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         bad_par, bad_stop;
    clear_obs();
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 5))
        0, 5:    b = 8'h29;
        1:       b = 8'hF0;
        2:       b = 8'hE0;
        3:       b = 8'h1C;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad_par  = 1'b0;
      bad_stop = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) bad_par = 1'b1;
        else bad_stop = 1'b1;
      end
      send_frame(b, bad_par, bad_stop, 1'($urandom_range(0, 1)));
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_event%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (n_ferr_obs != n_ferr_exp) begin
      n_fail++;
      $display("FAIL random_frame_err: got %0d want %0d", n_ferr_obs, n_ferr_exp);
    end
    n_checks++;
    if (bus.space_held !== m_held || n_stray_sp != 0 || n_wide != 0) begin
      n_fail++;
      $display("FAIL random_state: got held=%b stray=%0d wide=%0d want %b 0 0",
               bus.space_held, n_stray_sp, n_wide, m_held);
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_space_press();
    test_typematic();
    test_parity_err();
    test_ext();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
